// File: rtl/trdb_pkg.sv
// trdb_pkg: shared E-Trace packet types and serializer constants.
// Header offsets describe the 32-bit header beat layout.
package trdb_pkg;

  localparam int unsigned PAYLOADLEN = 256;
  localparam int unsigned PLEN       = 6;
  localparam int unsigned BEATW      = 32;
  localparam int unsigned TSLEN      = 20;

  localparam int unsigned HDR_LEN_LSB = 0;
  localparam int unsigned HDR_LEN_W   = 8;
  localparam int unsigned HDR_FMT_LSB = 8;
  localparam int unsigned HDR_SUB_LSB = 10;
  localparam int unsigned HDR_TS_LSB  = 12;

  typedef enum logic [1:0] {
    F_OPT_EXT    = 2'h0,
    F_DIFF_DELTA = 2'h1,
    F_ADDR_ONLY  = 2'h2,
    F_SYNC       = 2'h3
  } trdb_format_e;

  typedef enum logic [1:0] {
    SF_START   = 2'h0,
    SF_TRAP    = 2'h1,
    SF_CONTEXT = 2'h2,
    SF_SUPPORT = 2'h3
  } trdb_subformat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD
  } trdb_ser_state_e;

endpackage

// File: rtl/trdb_packet_serializer.sv
// trdb_packet_serializer: one E-Trace packet in, 32-bit beats out
// (header beat, then payload LSB-first). Optional macro
// TRDB_TIMESTAMP_EN stamps a 20-bit cycle count into header [31:12].
// Ports: clk_i, rst_i (sync, active-high); pkt_* packet handshake;
// beat_* valid/ready beat stream; len_err_o sticky length overflow.
module trdb_packet_serializer #(
  parameter int unsigned PAYLOADLEN = 256,
  parameter int unsigned PLEN       = 6,
  parameter int unsigned BEATW      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pkt_valid_i,
  output logic                  pkt_ready_o,
  input  logic [1:0]            pkt_format_i,
  input  logic [1:0]            pkt_subformat_i,
  input  logic [PLEN-1:0]       pkt_len_i,
  input  logic [PAYLOADLEN-1:0] pkt_payload_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [BEATW-1:0]      beat_data_o,
  output logic                  beat_last_o,
  output logic                  len_err_o
);
  import trdb_pkg::*;

  localparam int unsigned NBYTES = PAYLOADLEN / 8;
  localparam int unsigned NBEATS = PAYLOADLEN / BEATW;
  localparam int unsigned CNTW   =
    (NBEATS > 1) ? $clog2(NBEATS) : 1;

  trdb_ser_state_e       state_q, state_d;
  logic [PLEN-1:0]       len_q, len_d;
  logic [PAYLOADLEN-1:0] pay_q, pay_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  beat_valid_q, beat_valid_d;
  logic [BEATW-1:0]      beat_data_q, beat_data_d;
  logic                  beat_last_q, beat_last_d;
  logic                  len_err_q, len_err_d;

  logic                  len_ovf;
  logic [PLEN-1:0]       len_c;
  logic [PAYLOADLEN-1:0] pay_m;
  logic [BEATW-1:0]      hdr;
  logic [PLEN:0]         nbeat;

`ifdef TRDB_TIMESTAMP_EN
  logic [TSLEN-1:0] ts_q, ts_d;
  assign ts_d = ts_q + 1'b1;
`endif

  assign len_ovf = pkt_len_i > PLEN'(NBYTES);
  assign len_c   = len_ovf ? PLEN'(NBYTES) : pkt_len_i;
  assign nbeat   = ({1'b0, len_q} + (PLEN+1)'(3)) >> 2;

  // Bytes past the length are zeroed at capture, so the
  // final beat comes out already masked.
  always_comb begin
    pay_m = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (PLEN'(i) < len_c)
        pay_m[8*i +: 8] = pkt_payload_i[8*i +: 8];
    end
  end

  always_comb begin
    hdr = '0;
    hdr[HDR_LEN_LSB +: HDR_LEN_W] = HDR_LEN_W'(len_c);
    hdr[HDR_FMT_LSB +: 2] = pkt_format_i;
    if (pkt_format_i == F_SYNC)
      hdr[HDR_SUB_LSB +: 2] = pkt_subformat_i;
`ifdef TRDB_TIMESTAMP_EN
    hdr[HDR_TS_LSB +: TSLEN] = ts_q;
`endif
  end

  // beat_last_q doubles as the exit condition in both
  // HEADER (len==0) and PAYLOAD (cnt == nbeat-1).
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    pay_d        = pay_q;
    cnt_d        = cnt_q;
    beat_valid_d = beat_valid_q;
    beat_data_d  = beat_data_q;
    beat_last_d  = beat_last_q;
    len_err_d    = len_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pkt_valid_i) begin
          state_d      = S_HEADER;
          len_d        = len_c;
          pay_d        = pay_m;
          beat_valid_d = 1'b1;
          beat_data_d  = hdr;
          beat_last_d  = (len_c == '0);
          if (len_ovf) len_err_d = 1'b1;
        end
      end
      S_HEADER, S_PAYLOAD: begin
        if (beat_ready_i) begin
          if (beat_last_q) begin
            state_d      = S_IDLE;
            beat_valid_d = 1'b0;
            beat_data_d  = '0;
            beat_last_d  = 1'b0;
          end else begin
            state_d = S_PAYLOAD;
            cnt_d   = (state_q == S_HEADER) ?
                      '0 : cnt_q + 1'b1;
            beat_data_d = pay_q[BEATW*cnt_d +: BEATW];
            beat_last_d =
              ((PLEN+1)'(cnt_d) == nbeat - 1'b1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      pay_q        <= '0;
      cnt_q        <= '0;
      beat_valid_q <= 1'b0;
      beat_data_q  <= '0;
      beat_last_q  <= 1'b0;
      len_err_q    <= 1'b0;
`ifdef TRDB_TIMESTAMP_EN
      ts_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      pay_q        <= pay_d;
      cnt_q        <= cnt_d;
      beat_valid_q <= beat_valid_d;
      beat_data_q  <= beat_data_d;
      beat_last_q  <= beat_last_d;
      len_err_q    <= len_err_d;
`ifdef TRDB_TIMESTAMP_EN
      ts_q         <= ts_d;
`endif
    end
  end

  assign pkt_ready_o  = (state_q == S_IDLE);
  assign beat_valid_o = beat_valid_q;
  assign beat_data_o  = beat_data_q;
  assign beat_last_o  = beat_last_q;
  assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// tb_trdb_packet_serializer: random and directed packets against a
// queue-based reference model of the beat stream.
module tb_trdb_packet_serializer;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         pkt_valid_i = 1'b0;
  logic         pkt_ready_o;
  logic [1:0]   pkt_format_i = '0;
  logic [1:0]   pkt_subformat_i = '0;
  logic [5:0]   pkt_len_i = '0;
  logic [255:0] pkt_payload_i = '0;
  logic         beat_valid_o;
  logic         beat_ready_i = 1'b1;
  logic [31:0]  beat_data_o;
  logic         beat_last_o;
  logic         len_err_o;

  trdb_packet_serializer dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pkt_valid_i    (pkt_valid_i),
    .pkt_ready_o    (pkt_ready_o),
    .pkt_format_i   (pkt_format_i),
    .pkt_subformat_i(pkt_subformat_i),
    .pkt_len_i      (pkt_len_i),
    .pkt_payload_i  (pkt_payload_i),
    .beat_valid_o   (beat_valid_o),
    .beat_ready_i   (beat_ready_i),
    .beat_data_o    (beat_data_o),
    .beat_last_o    (beat_last_o),
    .len_err_o      (len_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          acc_cyc[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  logic [19:0] ts_m = '0;
  bit          err_m = 0;
  bit          seen_rst = 0;
  bit          held = 0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: clamp length, header = len + 256*fmt
  // + 1024*sub(sync only) + 4096*ts; payload bytes
  // packed four per beat, bytes past length are zero.
  function automatic void push_pkt(
    input logic [1:0] f, input logic [1:0] s,
    input int len, input logic [255:0] p,
    input logic [19:0] ts);
    int    lc;
    int    nb;
    int    idx;
    longint h;
    beat_t b;
    lc = (len > 32) ? 32 : len;
    nb = (lc + 3) / 4;
    h  = longint'(lc) + 256 * longint'(f);
    if (f == 2'd3) h += 1024 * longint'(s);
`ifdef TRDB_TIMESTAMP_EN
    h += 4096 * longint'(ts);
`else
    if (ts != ts) h = 0;
`endif
    b.d = 32'(h);
    b.l = (nb == 0);
    exp_q.push_back(b);
    for (int k = 0; k < nb; k++) begin
      b.d = '0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        if (idx < lc)
          b.d = b.d | (32'(p[idx*8 +: 8]) << (8 * j));
      end
      b.l = (k == nb - 1);
      exp_q.push_back(b);
    end
  endfunction

  // Monitor at negedge: inputs and outputs are stable
  // and equal to what the next rising edge samples.
  always @(negedge clk_i) begin : mon
    beat_t b;
    if (seen_rst) begin
      chk("pkt_ready", 32'(pkt_ready_o),
          32'(exp_q.size() == 0));
      chk("beat_valid", 32'(beat_valid_o),
          32'(exp_q.size() != 0));
      chk("len_err", 32'(len_err_o), 32'(err_m));
      if (held) begin
        chk("stall_data", beat_data_o, hold_d);
        chk("stall_last", 32'(beat_last_o), 32'(hold_l));
      end
    end
    cyc++;
    if (rst_i) begin
      seen_rst = 1;
      exp_q.delete();
      ts_m   = '0;
      err_m  = 0;
      held   = 0;
    end else if (seen_rst) begin
      if (beat_valid_o && beat_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %h expected none",
                   beat_data_o);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", beat_data_o, b.d);
          chk("beat_last", 32'(beat_last_o), 32'(b.l));
        end
      end
      if (pkt_valid_i && pkt_ready_o) begin
        push_pkt(pkt_format_i, pkt_subformat_i,
                 int'(pkt_len_i), pkt_payload_i, ts_m);
        acc_cyc.push_back(cyc);
        if (pkt_len_i > 6'd32) err_m = 1;
      end
      held   = beat_valid_o && !beat_ready_i;
      hold_d = beat_data_o;
      hold_l = beat_last_o;
      ts_m   = ts_m + 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       beat_ready_i = 1'b1;
        1:       beat_ready_i = ~beat_ready_i;
        default: beat_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  function automatic logic [255:0] rnd_pay();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[32*i +: 32] = $urandom;
    return p;
  endfunction

  task automatic send(input logic [1:0] f,
                      input logic [1:0] s,
                      input logic [5:0] len,
                      input logic [255:0] p);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    pkt_valid_i     = 1'b1;
    pkt_format_i    = f;
    pkt_subformat_i = s;
    pkt_len_i       = len;
    pkt_payload_i   = p;
    while (!ok && n < 2000) begin
      @(negedge clk_i);
      if (pkt_ready_o) ok = 1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no ready expected ready");
    end
    @(posedge clk_i);
    #1;
    pkt_valid_i     = 1'b0;
    pkt_format_i    = 2'($urandom);
    pkt_subformat_i = 2'($urandom);
    pkt_len_i       = 6'($urandom);
    pkt_payload_i   = rnd_pay();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !pkt_ready_o) && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats left expected 0",
               exp_q.size());
    end
  endtask

  initial begin
    int d;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(pkt_ready_o), 32'd1);
    chk("rst_valid", 32'(beat_valid_o), 32'd0);
    chk("rst_data", beat_data_o, 32'd0);
    chk("rst_last", 32'(beat_last_o), 32'd0);
    chk("rst_err", 32'(len_err_o), 32'd0);
    rst_i = 1'b0;

    send(2'd2, 2'd0, 6'd6, 256'h060504030201);
    wait_idle();

    send(2'd3, 2'd1, 6'd0, rnd_pay());
    send(2'd2, 2'd3, 6'd4, rnd_pay());
    d = acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2];
    chk("b2b_gap", 32'(d), 32'd2);
    wait_idle();

    rdy_mode = 1;
    send(2'd1, 2'd2, 6'd32, rnd_pay());
    wait_idle();
    rdy_mode = 0;

    send(2'd0, 2'd3, 6'd40, rnd_pay());
    wait_idle();
    chk("err_set", 32'(len_err_o), 32'd1);
    send(2'd2, 2'd0, 6'd4, rnd_pay());
    wait_idle();
    chk("err_sticky", 32'(len_err_o), 32'd1);

    send(2'd3, 2'd2, 6'd32, rnd_pay());
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("midrst_valid", 32'(beat_valid_o), 32'd0);
    chk("midrst_ready", 32'(pkt_ready_o), 32'd1);
    chk("midrst_err", 32'(len_err_o), 32'd0);
    rst_i = 1'b0;
    send(2'd3, 2'd3, 6'd9, rnd_pay());
    wait_idle();

    for (int i = 0; i < 80; i++) begin
      rdy_mode = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      send(2'($urandom), 2'($urandom),
           6'($urandom_range(0, 40)), rnd_pay());
    end
    rdy_mode = 0;
    wait_idle();
    repeat (2) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
